// File: rtl/disp_reg_pkg.sv
// Package: disp_reg_pkg
// Shared definitions for the dispatcher register bank:
//   - byte offsets of the register map (CTRL, STATUS, ERR, TRIG_BASE, CNT_BASE)
//   - write/read handshake FSM state types
//   - trigger counter width, used when DISP_REG_TRIG_CNT_EN is defined
//   - wordIdx(): converts a byte offset to the decoded word index (bits [11:2])
package disp_reg_pkg;

  localparam int unsigned IDX_W = 10;
  localparam int unsigned CNT_W = 16;

  localparam logic [11:0] CTRL_OFFSET   = 12'h000;
  localparam logic [11:0] STATUS_OFFSET = 12'h004;
  localparam logic [11:0] ERR_OFFSET    = 12'h008;
  localparam logic [11:0] TRIG_BASE     = 12'h100;
  localparam logic [11:0] CNT_BASE      = 12'h200;

  typedef enum logic {W_IDLE, W_ACK} wr_state_t;
  typedef enum logic {R_IDLE, R_ACK} rd_state_t;

  function automatic logic [IDX_W-1:0] wordIdx(input logic [11:0] byteOffset);
    return byteOffset[11:2];
  endfunction

endpackage

// File: rtl/disp_reg_channel.sv
// Module: disp_reg_channel
// One dispatcher channel: argument register, busy flag, sticky error flag,
// one-cycle trigger pulse and, when DISP_REG_TRIG_CNT_EN is defined, a
// 16-bit wrapping count of issued triggers.
// Ports:
//   iClock, iReset   clock, synchronous active-low reset
//   iEn              global enable (CTRL.EN)
//   iTrigWrite       accepted host write to this channel's TRIG register
//   iWriteData       host write data (loaded into the argument register)
//   iErrClear        W1C clear of this channel's error flag
//   iDone            one-cycle completion pulse from the engine
//   oArg             argument register
//   oBusy, oErr      busy and sticky error flags
//   oTrigger         one-cycle start pulse
//   oCount           trigger count (only with DISP_REG_TRIG_CNT_EN)
module disp_reg_channel
  import disp_reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iEn,
  input  logic              iTrigWrite,
  input  logic [DATA_W-1:0] iWriteData,
  input  logic              iErrClear,
  input  logic              iDone,
  output logic [DATA_W-1:0] oArg,
  output logic              oBusy,
  output logic              oErr,
  output logic              oTrigger
`ifdef DISP_REG_TRIG_CNT_EN
  ,
  output logic [CNT_W-1:0]  oCount
`endif
);

  // A done pulse frees the channel at the same edge, so a trigger arriving
  // together with done sees the channel idle and is accepted without error.
  logic busyAfterDone;
  logic fire;
  logic errSet;

  assign busyAfterDone = oBusy & ~iDone;
  assign fire          = iTrigWrite & iEn & ~busyAfterDone;
  assign errSet        = iTrigWrite & busyAfterDone;

  always_ff @(posedge iClock) begin
    // NOTE: the argument register drives oChArg directly, so it is reset
    // like any control flop rather than left uninitialised as storage.
    if (!iReset) begin
      oArg     <= '0;
      oBusy    <= 1'b0;
      oErr     <= 1'b0;
      oTrigger <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (iTrigWrite) oArg <= iWriteData;
      oBusy    <= fire | busyAfterDone;
      oTrigger <= fire;
      // A set at the same edge as a clear wins.
      oErr     <= (oErr & ~iErrClear) | errSet;
    end
  end

`ifdef DISP_REG_TRIG_CNT_EN
  logic [CNT_W-1:0] trigCnt;

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      trigCnt <= '0;
    end else if (fire) begin
      trigCnt <= trigCnt + 1'b1;
    end
  end

  assign oCount = trigCnt;
`endif

endmodule

// File: rtl/disp_reg_bank.sv
// Module: disp_reg_bank
// Multi-channel dispatcher register bank. Decodes host writes/reads using a
// two-phase valid/ack handshake, holds per-channel arguments and issues
// one-cycle trigger pulses, tracking busy/error status until iDone.
// Optional feature macro: DISP_REG_TRIG_CNT_EN adds per-channel trigger
// counters readable at 0x200+4*ch.
// Ports:
//   iClock, iReset                 clock, synchronous active-low reset
//   iWriteAddress/Data/Valid       host write request, oWriteAck acknowledge
//   iReadAddress/Valid             host read request
//   oReadData, oReadAck            registered read data and acknowledge
//   oTrigger                       per-channel start pulse
//   oChArg                         per-channel argument, ch0 in LSBs
//   iDone                          per-channel completion pulse
//   oBusy                          per-channel busy flag
module disp_reg_bank
  import disp_reg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic [ADDR_W-1:0]        iWriteAddress,
  input  logic [DATA_W-1:0]        iWriteData,
  input  logic                     iWriteValid,
  output logic                     oWriteAck,
  input  logic [ADDR_W-1:0]        iReadAddress,
  output logic [DATA_W-1:0]        oReadData,
  input  logic                     iReadValid,
  output logic                     oReadAck,
  output logic [NUM_CH-1:0]        oTrigger,
  output logic [NUM_CH*DATA_W-1:0] oChArg,
  input  logic [NUM_CH-1:0]        iDone,
  output logic [NUM_CH-1:0]        oBusy
);

  localparam logic [IDX_W-1:0] CTRL_IDX   = wordIdx(CTRL_OFFSET);
  localparam logic [IDX_W-1:0] STATUS_IDX = wordIdx(STATUS_OFFSET);
  localparam logic [IDX_W-1:0] ERR_IDX    = wordIdx(ERR_OFFSET);
  localparam logic [IDX_W-1:0] TRIG_IDX   = wordIdx(TRIG_BASE);
`ifdef DISP_REG_TRIG_CNT_EN
  localparam logic [IDX_W-1:0] CNT_IDX    = wordIdx(CNT_BASE);
`endif

  wr_state_t wrState, wrNext;
  rd_state_t rdState, rdNext;

  logic              en;
  logic              wrAccept, rdAccept;
  logic              ctrlWrite, errWrite;
  logic [IDX_W-1:0]  wrIdx, rdIdx;
  logic [NUM_CH-1:0] trigWrite, errClear, errVec;
  logic [DATA_W-1:0] chArg [NUM_CH];
  logic [DATA_W-1:0] readMux;
`ifdef DISP_REG_TRIG_CNT_EN
  logic [CNT_W-1:0]  chCount [NUM_CH];
`endif

  // Only bits [11:2] select a register; the rest are don't-care.
  assign wrIdx = iWriteAddress[11:2];
  assign rdIdx = iReadAddress[11:2];

  logic unusedAddrBits;
  assign unusedAddrBits = ^{iWriteAddress[ADDR_W-1:12], iWriteAddress[1:0],
                            iReadAddress[ADDR_W-1:12], iReadAddress[1:0]};

  // State registers, enable bit and read data capture.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      wrState   <= W_IDLE;
      rdState   <= R_IDLE;
      en        <= 1'b1;
      oReadData <= '0;
    end else begin
      wrState <= wrNext;
      rdState <= rdNext;
      if (ctrlWrite) en <= iWriteData[0];
      if (rdAccept) oReadData <= readMux;
    end
  end

  // Write FSM: accept in W_IDLE, acknowledge for exactly one cycle in W_ACK.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    wrNext    = wrState;
    wrAccept  = 1'b0;
    oWriteAck = 1'b0;
    case (wrState)
      W_IDLE: if (iWriteValid) begin
        wrAccept = 1'b1;
        wrNext   = W_ACK;
      end
      W_ACK: begin
        oWriteAck = 1'b1;
        wrNext    = W_IDLE;
      end
      default: wrNext = W_IDLE;
    endcase
  end

  // Read FSM, same shape as the write side.
  always_comb begin
    rdNext   = rdState;
    rdAccept = 1'b0;
    oReadAck = 1'b0;
    case (rdState)
      R_IDLE: if (iReadValid) begin
        rdAccept = 1'b1;
        rdNext   = R_ACK;
      end
      R_ACK: begin
        oReadAck = 1'b1;
        rdNext   = R_IDLE;
      end
      default: rdNext = R_IDLE;
    endcase
  end

  // Write decode; unmapped addresses and channels beyond NUM_CH fall through.
  always_comb begin
    ctrlWrite = 1'b0;
    errWrite  = 1'b0;
    trigWrite = '0;
    if (wrAccept) begin
      if (wrIdx == CTRL_IDX) ctrlWrite = 1'b1;
      if (wrIdx == ERR_IDX)  errWrite  = 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (wrIdx == TRIG_IDX + IDX_W'(ch)) trigWrite[ch] = 1'b1;
      end
    end
  end

  assign errClear = errWrite ? iWriteData[NUM_CH-1:0] : '0;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : genCh
    disp_reg_channel #(.DATA_W(DATA_W)) uChannel (
      .iClock     (iClock),
      .iReset     (iReset),
      .iEn        (en),
      .iTrigWrite (trigWrite[ch]),
      .iWriteData (iWriteData),
      .iErrClear  (errClear[ch]),
      .iDone      (iDone[ch]),
      .oArg       (chArg[ch]),
      .oBusy      (oBusy[ch]),
      .oErr       (errVec[ch]),
      .oTrigger   (oTrigger[ch])
`ifdef DISP_REG_TRIG_CNT_EN
      ,
      .oCount     (chCount[ch])
`endif
    );
    assign oChArg[ch*DATA_W +: DATA_W] = chArg[ch];
  end

  // Read mux sees current register values, so a read accepted at the same
  // edge as a write returns the pre-write contents.
  always_comb begin
    readMux = '0;
    if (rdIdx == CTRL_IDX)   readMux = DATA_W'(en);
    if (rdIdx == STATUS_IDX) readMux = DATA_W'(oBusy);
    if (rdIdx == ERR_IDX)    readMux = DATA_W'(errVec);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (rdIdx == TRIG_IDX + IDX_W'(ch)) readMux = chArg[ch];
`ifdef DISP_REG_TRIG_CNT_EN
      if (rdIdx == CNT_IDX + IDX_W'(ch))  readMux = DATA_W'(chCount[ch]);
`endif
    end
  end

endmodule
